conv_unit_multi: RTL and testbench

//  Multi-channel sequential convolution unit: one D*F*F image window applied to K filters in parallel.
//  One float MAC lane per filter; one operand pair per lane per clock, so each window costs D*F*F feed cycles.

---
 rtl/conv_unit_multi_pkg.sv | 25 ++
 rtl/conv_unit_multi_lane_mac.sv | 114 +++++++++++
 rtl/conv_unit_multi.sv | 137 +++++++++++++
 tb/tb_conv_unit_multi.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_unit_multi_pkg.sv
// Shared types and helpers for the multi-channel convolution unit.
// Holds the FSM state encoding, the float zero constant and sizing helpers.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    HOLD  = 3'd4
  } state_t;

  localparam logic [31:0] FLOAT_ZERO = 32'h0000_0000;

  // Number of operand pairs in one window.
  function automatic int calc_n(input int d, input int f);
    return d * f * f;
  endfunction

  // Element counter width: wide enough to hold the value N.
  function automatic int idx_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/conv_unit_multi_lane_mac.sv
// One float MAC lane: acc <= clear ? 0 : acc + a*b (IEEE-754 single).
// Product and sum are each rounded to nearest-even. Subnormal operands and
// results are flushed to signed zero. NaN inputs propagate (made quiet),
// Inf propagates, Inf*0 and Inf-Inf give the default quiet NaN.
module conv_lane_mac
  import conv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] acc
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // Round-to-nearest-even of 1.m with guard/sticky, then range check.
  function automatic logic [31:0] fp_round(input logic s, input int e_in,
                                           input logic [22:0] m, input logic g,
                                           input logic st);
    logic [24:0] rm;
    int          e;
    e  = e_in;
    rm = {2'b01, m} + {24'd0, g & (st | m[0])};
    if (rm[24]) e = e + 1;
    if (e >= 255)    return {s, 8'hFF, 23'd0};
    else if (e <= 0) return {s, 31'd0};
    return {s, e[7:0], rm[24] ? 23'd0 : rm[22:0]};
  endfunction

  function automatic logic [31:0] fp_mul(input logic [31:0] x, input logic [31:0] y);
    logic        s;
    logic [47:0] p;
    int          e;
    logic        x_nan, y_nan, x_inf, y_inf, x_zero, y_zero;
    s      = x[31] ^ y[31];
    x_nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    y_nan  = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
    x_inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    y_inf  = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
    x_zero = (x[30:23] == 8'd0);
    y_zero = (y[30:23] == 8'd0);
    if (x_nan)                                     return {x[31:23], 1'b1, x[21:0]};
    else if (y_nan)                                return {y[31:23], 1'b1, y[21:0]};
    else if ((x_inf && y_zero) || (y_inf && x_zero)) return QNAN;
    else if (x_inf || y_inf)                       return {s, 8'hFF, 23'd0};
    else if (x_zero || y_zero)                     return {s, 31'd0};
    p = 48'({1'b1, x[22:0]}) * 48'({1'b1, y[22:0]});
    e = int'(x[30:23]) + int'(y[30:23]) - 127;
    if (p[47]) return fp_round(s, e + 1, p[46:24], p[23], |p[22:0]);
    return fp_round(s, e, p[45:23], p[22], |p[21:0]);
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] l, sm_op;
    logic [7:0]  d;
    logic [50:0] big, sm, r;
    logic [49:0] n;
    logic        sticky;
    int          p;
    logic        x_nan, y_nan, x_inf, y_inf, x_zero, y_zero;
    x_nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    y_nan  = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
    x_inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    y_inf  = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
    x_zero = (x[30:23] == 8'd0);
    y_zero = (y[30:23] == 8'd0);
    if (x_nan)                                   return {x[31:23], 1'b1, x[21:0]};
    else if (y_nan)                              return {y[31:23], 1'b1, y[21:0]};
    else if (x_inf && y_inf && (x[31] != y[31])) return QNAN;
    else if (x_inf)                              return x;
    else if (y_inf)                              return y;
    else if (x_zero && y_zero)                   return {x[31] & y[31], 31'd0};
    else if (x_zero)                             return y;
    else if (y_zero)                             return x;
    // Order by magnitude so the aligned difference is never negative.
    if (x[30:0] >= y[30:0]) begin l = x; sm_op = y; end
    else                    begin l = y; sm_op = x; end
    d   = l[30:23] - sm_op[30:23];
    big = {2'b01, l[22:0], 26'd0};
    sm  = {2'b01, sm_op[22:0], 26'd0};
    if (d > 8'd49) begin
      sm     = 51'd0;
      sticky = 1'b1;
    end else begin
      sticky = |(sm & ((51'd1 << d) - 51'd1));
      sm     = sm >> d;
    end
    sm[0] = sm[0] | sticky;
    r = (l[31] == sm_op[31]) ? big + sm : big - sm;
    if (r == 51'd0) return 32'h0000_0000;
    p = 0;
    for (int i = 0; i < 51; i++) if (r[i]) p = i;
    n = 50'(r << (50 - p));
    return fp_round(l[31], int'(l[30:23]) + p - 49, n[49:27], n[26], |n[25:0]);
  endfunction

  logic [31:0] r_acc;
  logic [31:0] w_prod;
  logic [31:0] w_sum;

  assign w_prod = fp_mul(a, b);
  assign w_sum  = fp_add(r_acc, w_prod);
  assign acc    = r_acc;

  // Accumulator: cleared at window start, otherwise adds the current product.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      r_acc <= FLOAT_ZERO;
    else if (clear) r_acc <= FLOAT_ZERO;
    else            r_acc <= w_sum;
  end

endmodule

// File: rtl/conv_unit_multi.sv
// Multi-channel sequential convolution unit: one D*F*F window against K
// filters, one float MAC lane per filter, one element per clock.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never waits on ready, data is held while valid && !ready.
// Optional feature macro RELU_EN: negative lane results (incl. -0.0) become +0.0.
// o_dbg_state exposes the FSM state for checkers.
module conv_unit_multi
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,  // lanes are IEEE single, so this stays 32
  parameter int D          = 1,
  parameter int F          = 5,
  parameter int K          = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [D*F*F*DATA_WIDTH-1:0]    image,
  input  logic [K*D*F*F*DATA_WIDTH-1:0]  filter,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [K*DATA_WIDTH-1:0]        result,
  output logic                           busy,
  output state_t                         o_dbg_state
);

  localparam int            N        = calc_n(D, F);
  localparam int            IW       = idx_width(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  state_t                      r_state;
  logic [IW-1:0]               r_idx;
  logic [N*DATA_WIDTH-1:0]     r_image;
  logic [K*N*DATA_WIDTH-1:0]   r_filter;
  logic [K*DATA_WIDTH-1:0]     r_result;
  logic                        r_out_valid;

  logic                        w_accept;
  logic                        w_clear;
  logic [DATA_WIDTH-1:0]       w_op_a;
  logic [DATA_WIDTH-1:0]       w_op_b [K];
  logic [DATA_WIDTH-1:0]       w_acc  [K];
  logic [K*DATA_WIDTH-1:0]     w_result_next;

  assign in_ready    = (r_state == IDLE) || ((r_state == HOLD) && out_ready);
  assign w_accept    = in_valid && in_ready;
  assign w_clear     = (r_state == CLEAR);
  assign busy        = (r_state != IDLE);
  assign out_valid   = r_out_valid;
  assign result      = r_result;
  assign o_dbg_state = r_state;

  // Operand select: element idx during FEED, +0.0 otherwise so lanes hold still.
  always_comb begin
    w_op_a = FLOAT_ZERO;
    for (int k = 0; k < K; k++) w_op_b[k] = FLOAT_ZERO;
    if (r_state == FEED) begin
      for (int i = 0; i < N; i++) begin
        if (r_idx == IW'(i)) begin
          w_op_a = r_image[(N-1-i)*DATA_WIDTH +: DATA_WIDTH];
          for (int k = 0; k < K; k++)
            w_op_b[k] = r_filter[(K*N-1-(k*N+i))*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  for (genvar k = 0; k < K; k++) begin : g_lane
    conv_lane_mac u_lane (
      .clk   (clk),
      .reset (reset),
      .clear (w_clear),
      .a     (w_op_a),
      .b     (w_op_b[k]),
      .acc   (w_acc[k])
    );
  end

  // Result word assembly, lane 0 on the MSB side, optional ReLU clamp.
  always_comb begin
    w_result_next = '0;
    for (int k = 0; k < K; k++) begin
`ifdef RELU_EN
      w_result_next[(K-1-k)*DATA_WIDTH +: DATA_WIDTH] =
        w_acc[k][DATA_WIDTH-1] ? FLOAT_ZERO : w_acc[k];
`else
      w_result_next[(K-1-k)*DATA_WIDTH +: DATA_WIDTH] = w_acc[k];
`endif
    end
  end

  // Control FSM, element counter, input latches and result register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_image     <= '0;
      r_filter    <= '0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_image  <= image;
        r_filter <= filter;
      end
      case (r_state)
        IDLE: if (w_accept) r_state <= CLEAR;
        CLEAR: begin
          r_idx   <= '0;
          r_state <= FEED;
        end
        FEED: begin
          if (r_idx == LAST_IDX) begin
            r_idx   <= '0;
            r_state <= DRAIN;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        DRAIN: begin
          r_result    <= w_result_next;
          r_out_valid <= 1'b1;
          r_state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= in_valid ? CLEAR : IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_unit_multi.sv
// Bench for conv_unit_multi: a small instance (D=1,F=2,K=2) for directed
// handshake/reset/special-value cases and a larger one (D=3,F=3,K=4) for
// random float windows against a real-arithmetic reference model.
// Honours RELU_EN the same way the design does.
module tb_conv_unit_multi;
  import conv_pkg::*;

  localparam int W  = 32;
  localparam int SD = 1, SF = 2, SK = 2, SN = SD*SF*SF;
  localparam int BD = 3, BF = 3, BK = 4, BN = BD*BF*BF;

`ifdef RELU_EN
  localparam logic [127:0] EXP_BASIC = {64'd0, 32'h4120_0000, 32'h0000_0000};
`else
  localparam logic [127:0] EXP_BASIC = {64'd0, 32'h4120_0000, 32'hC060_0000};
`endif
  localparam logic [127:0] EXP_SPECIAL = {64'd0, 32'h7F80_0000, 32'h7FC0_0000};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              s_reset, s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_busy;
  logic [SN*W-1:0]    s_image;
  logic [SK*SN*W-1:0] s_filter;
  logic [SK*W-1:0]    s_result;
  state_t             s_state;

  logic              b_reset, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [BN*W-1:0]    b_image;
  logic [BK*BN*W-1:0] b_filter;
  logic [BK*W-1:0]    b_result;
  state_t             b_state;

  conv_unit_multi #(.DATA_WIDTH(W), .D(SD), .F(SF), .K(SK)) u_dut_s (
    .clk(clk), .reset(s_reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .image(s_image), .filter(s_filter), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .result(s_result), .busy(s_busy), .o_dbg_state(s_state)
  );

  conv_unit_multi #(.DATA_WIDTH(W), .D(BD), .F(BF), .K(BK)) u_dut_b (
    .clk(clk), .reset(b_reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .image(b_image), .filter(b_filter), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .result(b_result), .busy(b_busy), .o_dbg_state(b_state)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [127:0] exp_q[$];
  logic [31:0]  cur_img [BN];
  logic [31:0]  cur_flt [BK*BN];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic real f2r(input logic [31:0] b);
    logic [63:0] d;
    if (b[30:23] == 8'd0) d = {b[31], 63'd0};
    else d = {b[31], 11'(b[30:23]) + 11'd896, b[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  // Real -> single, round to nearest even (values stay in the normal range).
  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [24:0] m;
    int          e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = int'(d[62:52]) - 1023 + 127;
    m = {2'b01, d[51:29]} + 25'(d[28] && ((|d[27:0]) || d[29]));
    if (m[24]) begin e++; m = m >> 1; end
    if (e >= 255) return {d[63], 8'hFF, 23'd0};
    if (e <= 0)   return {d[63], 31'd0};
    return {d[63], 8'(e), m[22:0]};
  endfunction

  // Each lane: single-precision product, then single-precision running sum in order.
  function automatic logic [127:0] model(input int n, input int k);
    logic [127:0] res;
    logic [31:0]  acc32, p32;
    res = '0;
    for (int l = 0; l < k; l++) begin
      acc32 = 32'h0;
      for (int i = 0; i < n; i++) begin
        p32   = r2f(f2r(cur_img[i]) * f2r(cur_flt[l*n+i]));
        acc32 = r2f(f2r(acc32) + f2r(p32));
      end
`ifdef RELU_EN
      if (acc32[31]) acc32 = 32'h0;
`endif
      res[(k-1-l)*32 +: 32] = acc32;
    end
    return res;
  endfunction

  function automatic logic [31:0] rand_f();
    if ($urandom_range(0, 9) == 0) return 32'h0;
    return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 23'($urandom)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic load_s();
    for (int i = 0; i < SN; i++) s_image[(SN-1-i)*W +: W] = cur_img[i];
    for (int j = 0; j < SK*SN; j++) s_filter[(SK*SN-1-j)*W +: W] = cur_flt[j];
  endtask

  task automatic load_b();
    for (int i = 0; i < BN; i++) b_image[(BN-1-i)*W +: W] = cur_img[i];
    for (int j = 0; j < BK*BN; j++) b_filter[(BK*BN-1-j)*W +: W] = cur_flt[j];
  endtask

  task automatic set_basic();
    cur_img[0] = 32'h3F80_0000; cur_img[1] = 32'h4000_0000;
    cur_img[2] = 32'h4040_0000; cur_img[3] = 32'h4080_0000;
    for (int i = 0; i < 4; i++) cur_flt[i] = 32'h3F80_0000;
    cur_flt[4] = 32'h3F00_0000; cur_flt[5] = 32'h0;
    cur_flt[6] = 32'h0;         cur_flt[7] = 32'hBF80_0000;
  endtask

  task automatic set_special();
    cur_img[0] = 32'h7F80_0000;
    for (int i = 1; i < 4; i++) cur_img[i] = 32'h3F80_0000;
    for (int i = 0; i < 4; i++) cur_flt[i] = 32'h3F80_0000;
    for (int i = 4; i < 8; i++) cur_flt[i] = 32'h0;
  endtask

  task automatic new_window_s();
    for (int i = 0; i < SN; i++) cur_img[i] = rand_f();
    for (int j = 0; j < SK*SN; j++) cur_flt[j] = rand_f();
    load_s();
  endtask

  task automatic new_window_b();
    for (int i = 0; i < BN; i++) cur_img[i] = rand_f();
    for (int j = 0; j < BK*BN; j++) cur_flt[j] = rand_f();
    load_b();
  endtask

  // Counts edges from the accept edge until out_valid shows; bounded.
  task automatic wait_out_s(output int lat);
    lat = 0;
    while (!s_out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // One window on the small unit with out_ready=1; entered at posedge+1 in IDLE.
  task automatic run_s_window(input string tag, input logic [127:0] want);
    int lat;
    load_s();
    s_in_valid = 1'b1;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    wait_out_s(lat);
    check({tag, "_latency"}, 128'(lat), 128'(SN + 2));
    check({tag, "_result"}, 128'(s_result), want);
    @(posedge clk); #1;
  endtask

  // Streams nwin random windows into the big unit; entered at posedge+1.
  task automatic run_stream(input int nwin, input bit rand_ready);
    int sent, got, cyc, last_acc;
    bit take_in, take_out;
    sent = 0; got = 0; cyc = 0; last_acc = -1;
    exp_q.delete();
    new_window_b();
    b_in_valid = 1'b1;
    while ((got < nwin) && (cyc < 5000)) begin
      b_out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      take_in  = b_in_valid && b_in_ready;
      take_out = b_out_valid && b_out_ready;
      if (take_out) begin
        check("stream_pending", 128'(sent > got), 128'(1));
        if (exp_q.size() > 0) check("stream_result", 128'(b_result), exp_q.pop_front());
        got++;
      end
      if (take_in) begin
        if (!rand_ready && last_acc >= 0)
          check("b2b_interval", 128'(cyc - last_acc), 128'(BN + 3));
        last_acc = cyc;
        exp_q.push_back(model(BN, BK));
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
      if (take_in) begin
        if (sent < nwin) new_window_b();
        else b_in_valid = 1'b0;
      end
    end
    check("stream_count", 128'(got), 128'(nwin));
    check("stream_leftover", 128'(exp_q.size()), 128'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    s_reset = 1'b1; b_reset = 1'b1;
    s_in_valid = 1'b0; s_out_ready = 1'b0; s_image = '0; s_filter = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_image = '0; b_filter = '0;
    repeat (3) @(posedge clk);
    #1;
    s_reset = 1'b0; b_reset = 1'b0;
    @(posedge clk); #1;

    check("rst_in_ready",  128'(s_in_ready),  128'(1));
    check("rst_out_valid", 128'(s_out_valid), 128'(0));
    check("rst_busy",      128'(s_busy),      128'(0));
    check("rst_result",    128'(s_result),    128'(0));
    check("rst_state",     128'(s_state),     128'(IDLE));

    // Basic window; upstream scribbles the inputs right after accept.
    set_basic();
    load_s();
    s_in_valid = 1'b1;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    s_image = '1; s_filter = '1;
    check("accept_busy", 128'(s_busy), 128'(1));
    check("accept_in_ready", 128'(s_in_ready), 128'(0));
    wait_out_s(lat);
    check("basic_latency", 128'(lat), 128'(SN + 2));
    check("basic_result", 128'(s_result), EXP_BASIC);

    // Downstream stalls 10 cycles while a new window is offered.
    set_special();
    load_s();
    s_in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("stall_out_valid", 128'(s_out_valid), 128'(1));
      check("stall_result",    128'(s_result),    EXP_BASIC);
      check("stall_in_ready",  128'(s_in_ready),  128'(0));
      check("stall_state",     128'(s_state),     128'(HOLD));
    end
    s_out_ready = 1'b1;
    #1;
    check("hold_in_ready", 128'(s_in_ready), 128'(1));
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    check("reaccept_out_valid", 128'(s_out_valid), 128'(0));
    check("reaccept_state", 128'(s_state), 128'(CLEAR));
    wait_out_s(lat);
    check("special_latency", 128'(lat), 128'(SN + 2));
    check("special_result", 128'(s_result), EXP_SPECIAL);
    @(posedge clk); #1;
    check("idle_out_valid", 128'(s_out_valid), 128'(0));
    check("idle_busy", 128'(s_busy), 128'(0));

    // Reset in the middle of FEED (idx=2).
    set_basic();
    load_s();
    s_in_valid = 1'b1;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midfeed_state", 128'(s_state), 128'(FEED));
    s_reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_out_valid", 128'(s_out_valid), 128'(0));
    check("midrst_busy",      128'(s_busy),      128'(0));
    check("midrst_result",    128'(s_result),    128'(0));
    check("midrst_in_ready",  128'(s_in_ready),  128'(1));
    s_reset = 1'b0;
    @(posedge clk); #1;
    set_basic();
    run_s_window("fresh_basic", EXP_BASIC);
    for (int w = 0; w < 3; w++) begin
      new_window_s();
      run_s_window("small_rand", model(SN, SK));
    end

    // Big unit: back-to-back, then random downstream backpressure.
    run_stream(4, 1'b0);
    run_stream(8, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
